// File: rtl/mux_deserializer.sv
// Rebuilds an 8-bit word from (index, bit) pairs of an 8:1 bit-select stream.
// Out-of-order indices and stalled sweeps abort the word and are counted.
module mux_deserializer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [2:0] a,
    input  logic       y,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       seq_err,
    output logic [7:0] frame_count,
    output logic [7:0] err_count
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] buffer, buffer_nxt;
    logic [2:0] expect_idx, expect_nxt;
    logic [7:0] idle_cnt, idle_nxt;
    logic [8:0] idle_inc;
    logic [7:0] data_nxt;
    logic       data_valid_nxt;
    logic       seq_err_nxt;
    logic [7:0] frame_nxt;
    logic [7:0] err_nxt;
    logic [7:0] err_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            buffer      <= '0;
            expect_idx  <= '0;
            idle_cnt    <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            seq_err     <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            buffer      <= buffer_nxt;
            expect_idx  <= expect_nxt;
            idle_cnt    <= idle_nxt;
            data        <= data_nxt;
            data_valid  <= data_valid_nxt;
            seq_err     <= seq_err_nxt;
            frame_count <= frame_nxt;
            err_count   <= err_nxt;
        end
    end

    assign idle_inc = {1'b0, idle_cnt} + 9'd1;
    assign err_sat  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    always_comb begin
        state_nxt      = state;
        buffer_nxt     = buffer;
        expect_nxt     = expect_idx;
        idle_nxt       = idle_cnt;
        data_nxt       = data;
        data_valid_nxt = 1'b0;
        seq_err_nxt    = 1'b0;
        frame_nxt      = frame_count;
        err_nxt        = err_count;

        case (state)
            IDLE: begin
                // Stray indices are dropped silently until a sweep starts at 0.
                if (valid && a == 3'd0) begin
                    buffer_nxt = {7'b0, y};
                    expect_nxt = 3'd1;
                    idle_nxt   = '0;
                    state_nxt  = COLLECT;
                end
            end

            COLLECT: begin
                if (valid) begin
                    idle_nxt = '0;
                    if (a == expect_idx) begin
                        buffer_nxt[a] = y;
                        expect_nxt    = expect_idx + 3'd1;
                        if (a == 3'd7) begin
                            data_nxt       = {y, buffer[6:0]};
                            data_valid_nxt = 1'b1;
                            frame_nxt      = frame_count + 8'd1;
                            buffer_nxt     = '0;
                            expect_nxt     = '0;
                            state_nxt      = IDLE;
                        end
                    end else begin
                        seq_err_nxt = 1'b1;
                        err_nxt     = err_sat;
                        buffer_nxt  = '0;
                        if (a == 3'd0) begin
                            buffer_nxt[0] = y;
                            expect_nxt    = 3'd1;
                        end else begin
                            expect_nxt = '0;
                            state_nxt  = IDLE;
                        end
                    end
                end else if (idle_inc >= TIMEOUT_W) begin
                    seq_err_nxt = 1'b1;
                    err_nxt     = err_sat;
                    buffer_nxt  = '0;
                    expect_nxt  = '0;
                    idle_nxt    = '0;
                    state_nxt   = IDLE;
                end else begin
                    idle_nxt = idle_inc[7:0];
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_deserializer.sv
// Directed bench for mux_deserializer: vector table plus long counter-limit sequences.
module tb_mux_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [2:0] a;
    logic       y;
    logic [7:0] data;
    logic       data_valid;
    logic       seq_err;
    logic [7:0] frame_count;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    mux_deserializer #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .a           (a),
        .y           (y),
        .data        (data),
        .data_valid  (data_valid),
        .seq_err     (seq_err),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [2:0] a;
        logic       y;
        logic [7:0] data;
        logic       dv;
        logic       se;
        logic [7:0] fc;
        logic [7:0] ec;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(logic r, logic v, logic [2:0] ai, logic yi,
                                logic [7:0] d, logic dv, logic se,
                                logic [7:0] fc, logic [7:0] ec);
        vec_t t;
        t.rst_n = r; t.valid = v; t.a = ai; t.y = yi;
        t.data = d; t.dv = dv; t.se = se; t.fc = fc; t.ec = ec;
        vq.push_back(t);
    endfunction

    // Full in-order sweep of word x; completion shows on the a=7 entry.
    function automatic void add_sweep(logic [7:0] x, logic [7:0] prev,
                                      logic [7:0] fc_after, logic [7:0] ec);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) add(1, 1, 3'(i), x[i], x, 1, 0, fc_after, ec);
            else        add(1, 1, 3'(i), x[i], prev, 0, 0, fc_after - 8'd1, ec);
        end
    endfunction

    task automatic check(string name, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual %02h required %02h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic v, logic [2:0] ai, logic yi);
        rst_n = r; valid = v; a = ai; y = yi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] exp_data;
        logic [7:0] exp_fc;
        logic [7:0] exp_ec;

        rst_n = 1'b0; valid = 1'b0; a = '0; y = 1'b0;

        // Reset, then reset in the middle of a sweep (also while valid is high)
        add(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 3'(i), 1, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 0, 0, 0, 0);
        add_sweep(8'hA5, 8'h00, 1, 0);
        // Back-to-back sweeps
        add_sweep(8'h3C, 8'hA5, 2, 0);
        add_sweep(8'hC3, 8'h3C, 3, 0);
        // Out-of-order index aborts to IDLE
        add(1, 1, 0, 0, 8'hC3, 0, 0, 3, 0);
        add(1, 1, 1, 0, 8'hC3, 0, 0, 3, 0);
        add(1, 1, 2, 0, 8'hC3, 0, 0, 3, 0);
        add(1, 1, 5, 0, 8'hC3, 0, 1, 3, 1);
        // Index 0 mid-sweep aborts and restarts
        add(1, 1, 0, 1, 8'hC3, 0, 0, 3, 1);
        add(1, 1, 1, 1, 8'hC3, 0, 0, 3, 1);
        add(1, 1, 0, 0, 8'hC3, 0, 1, 3, 2);
        x = 8'h5A;
        for (int i = 1; i < 8; i++) begin
            if (i == 7) add(1, 1, 3'(i), x[i], 8'h5A, 1, 0, 4, 2);
            else        add(1, 1, 3'(i), x[i], 8'hC3, 0, 0, 3, 2);
        end
        // Timeout on the 4th idle cycle, then a=3 in IDLE is ignored
        for (int i = 0; i < 3; i++) add(1, 1, 3'(i), 1, 8'h5A, 0, 0, 4, 2);
        for (int i = 0; i < 3; i++) add(1, 0, 3, 1, 8'h5A, 0, 0, 4, 2);
        add(1, 0, 3, 1, 8'h5A, 0, 1, 4, 3);
        add(1, 1, 3, 1, 8'h5A, 0, 0, 4, 3);
        add(1, 1, 4, 0, 8'h5A, 0, 0, 4, 3);
        // Three idle cycles are tolerated
        for (int i = 0; i < 3; i++) add(1, 1, 3'(i), 1, 8'h5A, 0, 0, 4, 3);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 8'h5A, 0, 0, 4, 3);
        add(1, 1, 3, 1, 8'h5A, 0, 0, 4, 3);
        for (int i = 4; i < 7; i++) add(1, 1, 3'(i), 0, 8'h5A, 0, 0, 4, 3);
        add(1, 1, 7, 0, 8'h0F, 1, 0, 5, 3);
        // IDLE filtering
        for (int i = 0; i < 3; i++) add(1, 1, 4, 1, 8'h0F, 0, 0, 5, 3);
        add(1, 0, 4, 1, 8'h0F, 0, 0, 5, 3);

        foreach (vq[k]) begin
            drive(vq[k].rst_n, vq[k].valid, vq[k].a, vq[k].y);
            check("data",        k, data,        vq[k].data);
            check("data_valid",  k, 8'(data_valid), 8'(vq[k].dv));
            check("seq_err",     k, 8'(seq_err),    8'(vq[k].se));
            check("frame_count", k, frame_count, vq[k].fc);
            check("err_count",   k, err_count,   vq[k].ec);
        end

        // 256 good sweeps: frame_count wraps through 0 back to its start value
        exp_data = 8'h0F; exp_fc = 8'd5; exp_ec = 8'd3;
        for (int s = 0; s < 256; s++) begin
            x = 8'(s * 37 + 11);
            for (int i = 0; i < 8; i++) begin
                drive(1, 1, 3'(i), x[i]);
                if (i == 7) begin
                    exp_data = x;
                    exp_fc   = exp_fc + 8'd1;
                    check("wrap_dv",   s, 8'(data_valid), 8'd1);
                    check("wrap_data", s, data, exp_data);
                    check("wrap_fc",   s, frame_count, exp_fc);
                end
                check("wrap_se", s, 8'(seq_err), 8'd0);
            end
        end
        check("wrap_final_fc", 0, frame_count, 8'd5);

        // 300 aborts: repeated a=0 inside COLLECT each abort and restart
        drive(1, 1, 0, 1);
        check("abort_enter_se", 0, 8'(seq_err), 8'd0);
        for (int n = 0; n < 300; n++) begin
            drive(1, 1, 0, 1);
            if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
            check("abort_se", n, 8'(seq_err), 8'd1);
            check("abort_dv", n, 8'(data_valid), 8'd0);
            check("abort_ec", n, err_count, exp_ec);
        end
        drive(1, 1, 3, 0);
        check("sat_se",   0, 8'(seq_err), 8'd1);
        check("sat_ec",   0, err_count, 8'hFF);
        check("sat_data", 0, data, exp_data);
        check("sat_fc",   0, frame_count, exp_fc);

        // Back in IDLE: a clean sweep still completes
        x = 8'h96;
        for (int i = 0; i < 8; i++) drive(1, 1, 3'(i), x[i]);
        check("post_dv",   0, 8'(data_valid), 8'd1);
        check("post_data", 0, data, 8'h96);
        check("post_fc",   0, frame_count, exp_fc + 8'd1);
        check("post_ec",   0, err_count, 8'hFF);
        drive(1, 0, 0, 0);
        check("post_dv_drop", 0, 8'(data_valid), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_deserializer.md
# mux_deserializer

Receive-side counterpart of the 8:1 bit-select path. It samples the selected bit `y` together with its select index `a` and rebuilds the original 8-bit word over a full index sweep 0..7. Out-of-order or stalled sweeps are flagged and counted. It sits downstream of the bit-select stage in the lab designs and benches, and returns a parallel byte for comparison against the driven `x`.

## Interface
Parameters:
- `TIMEOUT`, 16: idle cycles (`valid` low) tolerated mid-sweep before abort; legal range 1..255.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `valid` input 1: `a`/`y` pair is meaningful this cycle.
- `a` input 3: bit index of `y`.
- `y` input 1: selected bit value.
- `data` output 8: last completed word; holds until the next completion.
- `data_valid` output 1: one-cycle pulse, `data` updated.
- `seq_err` output 1: one-cycle pulse, sweep aborted.
- `frame_count` output 8: completed words, wraps 255→0.
- `err_count` output 8: aborts, saturates at 255.

## Operation
- Reset (`rst_n`=0 at a clock edge): state IDLE; `data`=0, `data_valid`=0, `seq_err`=0, `frame_count`=0, `err_count`=0, shift buffer=0, `expect`=0, idle counter=0. Reset overrides any sweep in progress.
- State IDLE:
  - `valid`=1 with `a`=0: buffer[0]←`y`, `expect`←1, go to COLLECT.
  - `valid`=1 with `a`≠0: ignored. No error is raised.
  - `valid`=0: stay in IDLE.
- State COLLECT:
  - `valid`=1 with `a`==`expect`: buffer[a]←`y`, idle counter←0, `expect`←`expect`+1.
    - If `a`=7: `data`←{`y`, buffer[6:0]}, pulse `data_valid`, `frame_count`+1, go to IDLE.
  - `valid`=1 with `a`≠`expect`: pulse `seq_err`, `err_count`+1 (saturating), clear the buffer.
    - If `a`=0: restart with buffer[0]←`y`, `expect`←1, stay in COLLECT.
    - Otherwise: go to IDLE.
  - `valid`=0: idle counter+1. When it reaches `TIMEOUT`: pulse `seq_err`, `err_count`+1, go to IDLE.
- Back-to-back sweeps: a word completing on `a`=7 is followed the next cycle by `a`=0, which starts a new sweep from IDLE with no lost cycle.
- `data` changes only on completion. An aborted sweep never alters `data`.

## Timing
- Latency: `data`/`data_valid` are registered. They are visible in the cycle after the edge that samples `a`=7.
- `data_valid` and `seq_err` are each high for exactly one cycle and are never high together.
- Counters update on the same edge as their pulse.
- Throughput: one word per 8 `valid` cycles.
- Timeout abort fires on the `TIMEOUT`-th consecutive low-`valid` cycle in COLLECT. A `valid`=1 on that same edge takes priority (normal capture, no abort).
- `frame_count` wrap and `err_count` saturation are silent: no flag is raised.

## Test plan
- Reset mid-sweep: feed `a`=0..3, then assert `rst_n`=0 for 1 cycle → all outputs 0. A following sweep with `x`=8'hA5 yields `data`=8'hA5 and `frame_count`=1.
- Continuous sweeps: `valid`=1 and `a` cycling 0..7 with `y`=`x`[a], using `x`=8'h3C then 8'hC3 → `data_valid` pulses 8 cycles apart, `data`=8'h3C then 8'hC3, `frame_count`=2, `seq_err` never high.
- Sequence error: `a`=0,1,2,5 → `seq_err` pulse one cycle after the `a`=5 sample, `err_count`=1, `data` unchanged. Sending `a`=0,1,0 instead → error, then restart, and a full sweep afterwards still completes correctly.
- Timeout: `TIMEOUT`=4; after `a`=0..2, drive `valid`=0 for 4 cycles → `seq_err` pulse, `err_count`=1, state IDLE. With 3 low cycles then `a`=3, the sweep continues normally.
- Counter limits: run 256 good sweeps → `frame_count` wraps to 0. Run 300 aborts → `err_count`=255.
- IDLE filtering: `valid` pulses with `a`=4 while in IDLE → no pulses, counters unchanged.
